pipeline_stage_reg: RTL and testbench
=====================================

# pipeline_stage_reg

Parametrised, handshaked pipeline stage register that replaces the fixed-field inter-stage registers (D→E, E→M, M→W) with one reusable block. The payload is an opaque `WIDTH`-bit vector; the producing stage packs its fields and the consuming stage unpacks them. Compared with the fixed registers it adds valid/ready flow control, a stall input from the hazard unit, a flush that inserts a configurable bubble, an optional 2-entry skid buffer that registers the ready path, and a saturating stall-cycle counter for performance debug.

## Interface

Parameters:
- `WIDTH`, default 128: payload width in bits, must be ≥1.
- `BUBBLE_VALUE`, default `'0`: payload presented whenever the output is not valid. The stage instance sets this to its encoded NULL instruction.
- `SKID`, default 1: 1 uses a 2-entry skid buffer with a registered `oReady`; 0 uses a single entry with a combinational `oReady`.
- `CNT_W`, default 16: stall counter width, must be ≥1.

Ports:
- `iClk`, input, 1 bit: clock. All state updates on the rising edge.
- `iRst`, input, 1 bit: reset, asynchronous and active-high.
- `iValid`, input, 1 bit: upstream payload valid.
- `oReady`, output, 1 bit: this stage can accept a payload.
- `iData`, input, `WIDTH` bits: upstream payload.
- `oValid`, output, 1 bit: downstream payload valid.
- `iReady`, input, 1 bit: downstream can accept.
- `oData`, output, `WIDTH` bits: downstream payload.
- `iStall`, input, 1 bit: hazard-unit stall. Forces a hold exactly as `iReady`=0 does.
- `iFlush`, input, 1 bit: synchronous kill of all held entries.
- `iClrCnt`, input, 1 bit: synchronous clear of `oStallCnt`.
- `oStallCnt`, output, `CNT_W` bits: saturating count of stalled cycles.

## Operation

- Definitions: `in_fire` = `iValid & oReady`; `dn_rdy` = `iReady & ~iStall`; `out_fire` = `oValid & dn_rdy`.
- State: main entry M (valid bit plus data), which drives the outputs. When `SKID`=1 there is also a skid entry S (valid bit plus data).
- `oValid` = M.valid.
- `oData` = M.data when M.valid, otherwise `BUBBLE_VALUE`. The output never shows stale data.
- `oReady`:
  - `SKID`=1: `~S.valid`, taken straight from a register.
  - `SKID`=0: `~M.valid | dn_rdy`.
- Update with no flush, `SKID`=1:
  - If `out_fire` or M is empty:
    - M takes S if S.valid, and S is cleared. If `in_fire` also occurs in that case, the incoming payload goes to S.
    - Otherwise M takes the input if `in_fire`.
    - Otherwise M becomes empty.
  - If M is full and `out_fire`=0: `in_fire` writes S.
  - `in_fire` can never occur while S.valid, because `oReady` is low then.
- Update with no flush, `SKID`=0:
  - M takes the input when `in_fire`.
  - Otherwise M empties on `out_fire`.
  - Otherwise M holds.
- Flush (`iFlush`=1) has priority over every data update:
  - M.valid and S.valid are cleared.
  - An `in_fire` in the flush cycle is consumed and discarded.
  - An `out_fire` in the flush cycle counts as delivered.
- Stall counter:
  - Increments in every cycle where `oValid & ~dn_rdy`, including flush cycles.
  - Saturates at all-ones.
  - `iClrCnt` clears it to 0 and wins over an increment in the same cycle.
- Ordering: strict FIFO. No payload is duplicated or dropped, except by flush.

## Timing

- Reset values (asynchronous, applied while `iRst`=1):
  - M.valid=0 and S.valid=0.
  - `oValid`=0, `oData`=`BUBBLE_VALUE`.
  - `oReady`=1.
  - `oStallCnt`=0.
- Latency: when the stage is empty, an `in_fire` at edge N gives `oValid`=1 with that data after edge N. That is 1 cycle.
- Throughput: 1 payload per cycle while `dn_rdy`=1, for both `SKID` values.
- `SKID`=1:
  - There is no combinational path from `iReady` or `iStall` to `oReady`.
  - `oReady` drops one cycle after the first held `in_fire`.
  - It rises one cycle after the first `out_fire` that drains S.
  - At most 2 payloads are held.
- `SKID`=0:
  - `oReady` depends combinationally on `iReady` and `iStall`.
  - At most 1 payload is held.
- Flush: outputs show a bubble in the cycle after the flush edge. When `SKID`=1, `oReady`=1 in that cycle.
- Reset mid-transfer: all held payloads are lost immediately. The first `in_fire` after `iRst` deasserts behaves as the first transfer into an empty stage.

## Test plan

- Reset and idle:
  - Stimulus: `WIDTH`=8, `BUBBLE_VALUE`=8'hFF, assert `iRst` asynchronously mid-cycle.
  - Required response: `oValid`=0, `oData`=8'hFF and `oReady`=1 immediately; `oStallCnt`=0.
- Streaming:
  - Stimulus: `iReady`=1, values 1, 2, 3, 4 on consecutive cycles.
  - Required response: `oData` shows 1, 2, 3, 4, each one cycle later, with `oValid` continuously high.
- Skid fill (`SKID`=1):
  - Stimulus: `iReady`=0, push A then B.
  - Required response:
    - `oReady` goes low after B; C is held off upstream.
    - After `iReady`=1, the outputs are A, then B, then C.
    - `oStallCnt`=2.
- Stall versus ready:
  - Stimulus: `iReady`=1, `iStall`=1 for 3 cycles while holding payload 0x5A.
  - Required response: `oData` stays 0x5A for those 3 cycles; `oStallCnt` increases by 3.
- Flush with both entries full and `in_fire` in the same cycle:
  - Required response: the next cycle has `oValid`=0, `oData`=`BUBBLE_VALUE` and `oReady`=1, and the flushed input never appears at the output.
- Counter saturation and clear:
  - Stimulus: `CNT_W`=2, hold `oValid` with `iReady`=0 for 6 cycles.
  - Required response: `oStallCnt` reads 3 and stays there. `iClrCnt`=1 together with a stalled cycle gives 0.
- Repeat all scenarios with `SKID`=0; the skid-fill scenario then requires `oReady` to fall in the same cycle that `iReady` goes low.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// ---------------------------------------------------------------------------
// pipeline_stage_reg
//
// Reusable handshaked register placed between two pipeline stages. The
// payload is an opaque WIDTH-bit vector: the producer packs its fields and
// the consumer unpacks them. On top of a plain register it provides
// valid/ready flow control, a hazard-unit stall, a flush that turns the
// stage into a bubble, an optional 2-entry skid buffer that takes oReady
// straight from a flop, and a saturating stall-cycle counter for debug.
//
// Parameters:
//   WIDTH        payload width in bits (>= 1)
//   BUBBLE_VALUE payload shown on oData whenever oValid is low
//   SKID         1: main + skid entry, registered oReady
//                0: single entry, combinational oReady
//   CNT_W        stall counter width (>= 1)
//
// Ports:
//   iClk       clock, rising edge
//   iRst       asynchronous active-high reset
//   iValid     upstream payload valid
//   oReady     this stage can accept a payload
//   iData      upstream payload
//   oValid     downstream payload valid
//   iReady     downstream can accept
//   oData      downstream payload (BUBBLE_VALUE when not valid)
//   iStall     hazard stall, behaves exactly like iReady = 0
//   iFlush     synchronous kill of every held entry
//   iClrCnt    synchronous clear of oStallCnt
//   oStallCnt  saturating count of cycles with oValid held by the consumer
// ---------------------------------------------------------------------------
module pipeline_stage_reg #(
  parameter int               WIDTH        = 128,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
  parameter int               SKID         = 1,
  parameter int               CNT_W        = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  input  logic             iStall,
  input  logic             iFlush,
  input  logic             iClrCnt,
  output logic [CNT_W-1:0] oStallCnt
);

  logic             mValid;
  logic [WIDTH-1:0] mData;
  logic             inFire;
  logic             dnRdy;
  logic             outFire;
  logic [CNT_W-1:0] stallCnt;

  // Handshake terms shared by both buffer styles. A hazard stall is folded
  // into the downstream ready so the rest of the logic only sees one hold.
  assign dnRdy   = iReady & ~iStall;
  assign outFire = mValid & dnRdy;
  assign inFire  = iValid & oReady;

  // The main entry always drives the outputs; an empty stage shows the
  // bubble instead of whatever stale payload is still sitting in mData.
  assign oValid    = mValid;
  assign oData     = mValid ? mData : BUBBLE_VALUE;
  assign oStallCnt = stallCnt;

  generate
    if (SKID != 0) begin : gSkid
      logic             sValid;
      logic [WIDTH-1:0] sData;

      // oReady comes only from the skid valid flop, which cuts the timing
      // path from the consumer's ready/stall back into the producer.
      assign oReady = ~sValid;

      // Two-entry skid buffer. When the main entry moves on (or is empty)
      // it refills from the skid entry first to keep FIFO order; only when
      // the skid entry is empty does the incoming payload go straight to M.
      // While M is held, an accepted payload parks in S, which then drops
      // oReady on the following cycle. Flush overrides every data move.
      always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
          mValid <= 1'b0;
          mData  <= '0;
          sValid <= 1'b0;
          sData  <= '0;
        end else if (iFlush) begin
          mValid <= 1'b0;
          sValid <= 1'b0;
        end else if (outFire || !mValid) begin
          if (sValid) begin
            mValid <= 1'b1;
            mData  <= sData;
            sValid <= inFire;
            if (inFire) begin
              sData <= iData;
            end
          end else if (inFire) begin
            mValid <= 1'b1;
            mData  <= iData;
          end else begin
            mValid <= 1'b0;
          end
        end else if (inFire) begin
          sValid <= 1'b1;
          sData  <= iData;
        end
      end
    end else begin : gNoSkid
      // Single entry: the stage can accept whenever it is empty or its
      // current payload leaves this cycle, so oReady follows iReady/iStall
      // combinationally.
      assign oReady = ~mValid | dnRdy;

      // Single-entry register. A new payload overwrites the departing one;
      // otherwise a delivered payload empties the entry. Flush wins.
      always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
          mValid <= 1'b0;
          mData  <= '0;
        end else if (iFlush) begin
          mValid <= 1'b0;
        end else if (inFire) begin
          mValid <= 1'b1;
          mData  <= iData;
        end else if (outFire) begin
          mValid <= 1'b0;
        end
      end
    end
  endgenerate

  // Stall counter: counts every cycle a valid payload is held by the
  // consumer (flush cycles included), sticks at all-ones, and a clear
  // request beats an increment in the same cycle.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stallCnt <= '0;
    end else if (iClrCnt) begin
      stallCnt <= '0;
    end else if (mValid && !dnRdy && !(&stallCnt)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stage_reg
//
// Bench for pipeline_stage_reg. Two instances (SKID = 1 and SKID = 0) share
// the stimulus; sel picks which one the upstream valid goes to and which
// one's outputs are observed. Every accepted payload is pushed to a
// scoreboard queue and popped when the stage delivers it downstream.
// ---------------------------------------------------------------------------
module tb_pipeline_stage_reg;

  logic       iClk;
  logic       iRst;
  logic       iValid;
  logic [7:0] iData;
  logic       iReady;
  logic       iStall;
  logic       iFlush;
  logic       iClrCnt;
  bit         sel;

  logic       valid1In, valid0In;
  logic       ready1, ready0;
  logic       oValid1, oValid0;
  logic [7:0] oData1, oData0;
  logic [1:0] cnt1, cnt0;

  logic       curReady, curValid;
  logic [7:0] curData;
  logic [1:0] curCnt;

  logic [7:0] sb[$];
  int         checks = 0;
  int         errors = 0;

  // Route the upstream valid to the selected instance only; the other one
  // stays idle and is simply ignored.
  assign valid1In = iValid & sel;
  assign valid0In = iValid & ~sel;
  assign curReady = sel ? ready1  : ready0;
  assign curValid = sel ? oValid1 : oValid0;
  assign curData  = sel ? oData1  : oData0;
  assign curCnt   = sel ? cnt1    : cnt0;

  pipeline_stage_reg #(.WIDTH(8), .BUBBLE_VALUE(8'hFF), .SKID(1), .CNT_W(2)) dutSkid (
    .iClk(iClk), .iRst(iRst), .iValid(valid1In), .oReady(ready1), .iData(iData),
    .oValid(oValid1), .iReady(iReady), .oData(oData1), .iStall(iStall),
    .iFlush(iFlush), .iClrCnt(iClrCnt), .oStallCnt(cnt1)
  );

  pipeline_stage_reg #(.WIDTH(8), .BUBBLE_VALUE(8'hFF), .SKID(0), .CNT_W(2)) dutNoSkid (
    .iClk(iClk), .iRst(iRst), .iValid(valid0In), .oReady(ready0), .iData(iData),
    .oValid(oValid0), .iReady(iReady), .oData(oData0), .iStall(iStall),
    .iFlush(iFlush), .iClrCnt(iClrCnt), .oStallCnt(cnt0)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // One clock cycle of stimulus with inputs already set by the caller.
  // Samples handshakes mid-cycle, scores any delivered payload against the
  // queue, records accepted payloads (or wipes the queue on flush), then
  // advances to the next falling edge.
  task automatic applyStimulus(output bit fired);
    bit inF, outF;
    logic [7:0] exp;
    #1;
    inF  = iValid & curReady;
    outF = curValid & iReady & ~iStall;
    if (outF) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected sel=%0d: got %h, required no output", sel, curData);
      end else begin
        exp = sb.pop_front();
        if (curData !== exp) begin
          errors++;
          $display("[TB] FAIL sb_data sel=%0d: got %h, required %h", sel, curData, exp);
        end
      end
    end
    if (iFlush) sb.delete();
    else if (inF) sb.push_back(iData);
    fired = inF;
    @(negedge iClk);
  endtask

  // Return to a known idle state: reset pulse, quiet inputs, empty queue.
  task automatic doReset();
    iRst = 1'b1; iValid = 1'b0; iData = 8'h00; iReady = 1'b0;
    iStall = 1'b0; iFlush = 1'b0; iClrCnt = 1'b0;
    #2;
    iRst = 1'b0;
    sb.delete();
    @(negedge iClk);
  endtask

  // Let everything held drain out, bounded so a stuck stage cannot hang us.
  task automatic drain();
    bit f;
    iValid = 1'b0; iReady = 1'b1; iStall = 1'b0; iFlush = 1'b0; iClrCnt = 1'b0;
    for (int i = 0; i < 12 && sb.size() != 0; i++) applyStimulus(f);
    applyStimulus(f);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout sel=%0d: got %0d payloads left, required 0", sel, sb.size());
    end
  endtask

  // Asynchronous reset mid-cycle with payloads held, then a fresh transfer.
  task automatic test_reset();
    bit f;
    iReady = 1'b0; iValid = 1'b1; iData = 8'h61; applyStimulus(f);
    iData = 8'h62; applyStimulus(f);
    iValid = 1'b0;
    #2 iRst = 1'b1;
    #1;
    checks++;
    if (curValid !== 1'b0 || curData !== 8'hFF || curReady !== 1'b1 || curCnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_state sel=%0d: got v=%b d=%h r=%b c=%0d, required v=0 d=ff r=1 c=0",
               sel, curValid, curData, curReady, curCnt);
    end
    #1 iRst = 1'b0;
    sb.delete();
    @(negedge iClk);
    iReady = 1'b1; iValid = 1'b1; iData = 8'h63;
    applyStimulus(f);
    iValid = 1'b0;
    #1;
    checks++;
    if (curValid !== 1'b1 || curData !== 8'h63) begin
      errors++;
      $display("[TB] FAIL reset_first_xfer sel=%0d: got v=%b d=%h, required v=1 d=63", sel, curValid, curData);
    end
    drain();
  endtask

  // Back-to-back streaming: one payload per cycle, one cycle of latency.
  task automatic test_stream();
    bit f;
    iReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iValid = (i < 4);
      iData  = 8'(i + 1);
      #1;
      checks++;
      if (curReady !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_ready sel=%0d cyc=%0d: got %b, required 1", sel, i, curReady);
      end
      if (i > 0) begin
        checks++;
        if (curValid !== 1'b1 || curData !== 8'(i)) begin
          errors++;
          $display("[TB] FAIL stream_out sel=%0d cyc=%0d: got v=%b d=%h, required v=1 d=%h",
                   sel, i, curValid, curData, 8'(i));
        end
      end
      applyStimulus(f);
    end
    drain();
  endtask

  // Downstream blocks with A held; upstream keeps offering B then C.
  task automatic test_skid_fill();
    logic [7:0] items[3];
    int idx;
    bit f;
    items[0] = 8'hA1; items[1] = 8'hA2; items[2] = 8'hA3;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      iValid = (idx < 3);
      iData  = (idx < 3) ? items[idx] : 8'h00;
      iReady = (c == 0) || (c >= 3);
      #1;
      if (c == 1) begin
        checks++;
        if (curReady !== sel) begin
          errors++;
          $display("[TB] FAIL skid_ready_hold sel=%0d: got %b, required %b", sel, curReady, sel);
        end
      end
      if (c == 2) begin
        checks++;
        if (curReady !== 1'b0) begin
          errors++;
          $display("[TB] FAIL skid_ready_full sel=%0d: got %b, required 0", sel, curReady);
        end
      end
      if (c == 3) begin
        checks++;
        if (curCnt !== 2'd2 || curValid !== 1'b1 || curData !== 8'hA1) begin
          errors++;
          $display("[TB] FAIL skid_cnt_head sel=%0d: got c=%0d v=%b d=%h, required c=2 v=1 d=a1",
                   sel, curCnt, curValid, curData);
        end
      end
      applyStimulus(f);
      if (f) idx++;
    end
    drain();
  endtask

  // Hazard stall with iReady high must hold the payload like iReady low.
  task automatic test_stall();
    bit f;
    iReady = 1'b1; iValid = 1'b1; iData = 8'h5A;
    applyStimulus(f);
    iValid = 1'b0; iStall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (curValid !== 1'b1 || curData !== 8'h5A || curReady !== sel || curCnt !== 2'(c)) begin
        errors++;
        $display("[TB] FAIL stall_hold sel=%0d cyc=%0d: got v=%b d=%h r=%b c=%0d, required v=1 d=5a r=%b c=%0d",
                 sel, c, curValid, curData, curReady, curCnt, sel, c);
      end
      applyStimulus(f);
    end
    iStall = 1'b0;
    #1;
    checks++;
    if (curCnt !== 2'd3 || curData !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL stall_cnt sel=%0d: got c=%0d d=%h, required c=3 d=5a", sel, curCnt, curData);
    end
    drain();
  endtask

  // Flush with the stage full, then flush while data moves both ways.
  task automatic test_flush();
    bit f;
    iReady = 1'b0; iValid = 1'b1; iData = 8'h11;
    applyStimulus(f);
    iData = 8'h22;
    applyStimulus(f);
    iData = f ? 8'h33 : 8'h22;
    iFlush = 1'b1;
    #1;
    checks++;
    if (curReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_full_ready sel=%0d: got %b, required 0", sel, curReady);
    end
    applyStimulus(f);
    iFlush = 1'b0; iValid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (curValid !== 1'b0 || curData !== 8'hFF || curReady !== 1'b1) begin
        errors++;
        $display("[TB] FAIL flush_bubble sel=%0d cyc=%0d: got v=%b d=%h r=%b, required v=0 d=ff r=1",
                 sel, c, curValid, curData, curReady);
      end
      applyStimulus(f);
    end
    iReady = 1'b1; iValid = 1'b1; iData = 8'h44;
    applyStimulus(f);
    iData = 8'h55; iFlush = 1'b1;
    applyStimulus(f);
    iFlush = 1'b0; iValid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (curValid !== 1'b0 || curData !== 8'hFF || curReady !== 1'b1) begin
        errors++;
        $display("[TB] FAIL flush_fire_bubble sel=%0d cyc=%0d: got v=%b d=%h r=%b, required v=0 d=ff r=1",
                 sel, c, curValid, curData, curReady);
      end
      applyStimulus(f);
    end
    drain();
  endtask

  // 2-bit counter: six held cycles saturate at 3; clear beats increment.
  task automatic test_counter();
    bit f;
    for (int c = 0; c < 9; c++) begin
      iValid  = (c == 0);
      iData   = 8'h77;
      iReady  = 1'b0;
      iClrCnt = (c == 7);
      #1;
      if (c == 2) begin
        checks++;
        if (curCnt !== 2'd1) begin
          errors++;
          $display("[TB] FAIL cnt_inc sel=%0d: got %0d, required 1", sel, curCnt);
        end
      end
      if (c >= 4 && c <= 7) begin
        checks++;
        if (curCnt !== 2'd3) begin
          errors++;
          $display("[TB] FAIL cnt_sat sel=%0d cyc=%0d: got %0d, required 3", sel, c, curCnt);
        end
      end
      if (c == 8) begin
        checks++;
        if (curCnt !== 2'd0) begin
          errors++;
          $display("[TB] FAIL cnt_clr sel=%0d: got %0d, required 0", sel, curCnt);
        end
      end
      applyStimulus(f);
    end
    drain();
  endtask

  // Run every scenario against the skid instance, then the single-entry one.
  initial begin
    sel = 1'b1;
    doReset();
    for (int s = 1; s >= 0; s--) begin
      sel = (s == 1);
      doReset();
      test_reset();
      doReset();
      test_stream();
      doReset();
      test_skid_fill();
      doReset();
      test_stall();
      doReset();
      test_flush();
      doReset();
      test_counter();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
